// File: rtl/kernel_nios2_mul_pkg.sv
// Shared definitions for the Nios II kernel multiplier: op encoding, pipeline
// depth, and per-op operand signedness.
package kernel_nios2_mul_pkg;

    typedef enum logic [1:0] {
        OP_MUL    = 2'd0,
        OP_MULXSS = 2'd1,
        OP_MULXSU = 2'd2,
        OP_MULXUU = 2'd3
    } mul_op_e;

    localparam int MUL_LATENCY = 2;

    typedef struct packed {
        logic a_signed;
        logic b_signed;
    } op_sign_t;

    // MUL only keeps the low word, which does not depend on signedness.
    function automatic op_sign_t op_signedness(input mul_op_e op);
        op_sign_t s;
        case (op)
            OP_MULXSS: s = '{a_signed: 1'b1, b_signed: 1'b1};
            OP_MULXSU: s = '{a_signed: 1'b1, b_signed: 1'b0};
            OP_MULXUU: s = '{a_signed: 1'b0, b_signed: 1'b0};
            default:   s = '{a_signed: 1'b0, b_signed: 1'b0};
        endcase
        return s;
    endfunction

endpackage

// File: rtl/kernel_nios2_mul_pp.sv
// One (H+1)x(H+1) signed partial-product multiplier; each H-bit operand is
// sign- or zero-extended under control of its *_signed_i input.
module kernel_nios2_mul_pp #(
    parameter int H = 16
) (
    input  logic [H-1:0]          a_i,
    input  logic                  a_signed_i,
    input  logic [H-1:0]          b_i,
    input  logic                  b_signed_i,
    output logic signed [2*H+1:0] p_o
);

    logic signed [2*H+1:0] a_ext_s;
    logic signed [2*H+1:0] b_ext_s;

    assign a_ext_s = {{(H+2){a_signed_i & a_i[H-1]}}, a_i};
    assign b_ext_s = {{(H+2){b_signed_i & b_i[H-1]}}, b_i};
    assign p_o     = a_ext_s * b_ext_s;

endmodule

// File: rtl/kernel_nios2_mul_unit.sv
// Two-stage pipelined W x W multiplier: stage A forms four half-width partial
// products, stage B sums them and selects the low or high result word.
module kernel_nios2_mul_unit
    import kernel_nios2_mul_pkg::*;
#(
    parameter int W     = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_result,
    output logic [TAG_W-1:0] out_tag
);

    localparam int H  = W / 2;
    localparam int PW = W + 2;

    mul_op_e          op_in_s;
    op_sign_t         sign_in_s;
    logic signed [PW-1:0] pp_ll_s, pp_lh_s, pp_hl_s, pp_hh_s;
    logic             adv_a_s, adv_b_s, accept_s;

    logic             va_q, va_d;
    mul_op_e          op_a_q, op_a_d;
    logic [TAG_W-1:0] tag_a_q, tag_a_d;
    logic [PW-1:0]    pp_ll_q, pp_ll_d, pp_lh_q, pp_lh_d;
    logic [PW-1:0]    pp_hl_q, pp_hl_d, pp_hh_q, pp_hh_d;

    logic             vb_q, vb_d;
    logic [W-1:0]     res_q, res_d;
    logic [TAG_W-1:0] tag_b_q, tag_b_d;

    logic [2*W-1:0]   ll_ext_s, lh_ext_s, hl_ext_s, hh_ext_s, sum_s;
    logic [W-1:0]     res_sel_s;

    assign op_in_s   = mul_op_e'(in_op);
    assign sign_in_s = op_signedness(op_in_s);

    kernel_nios2_mul_pp #(.H(H)) u_pp_ll (
        .a_i(in_a[H-1:0]), .a_signed_i(1'b0),
        .b_i(in_b[H-1:0]), .b_signed_i(1'b0), .p_o(pp_ll_s));
    kernel_nios2_mul_pp #(.H(H)) u_pp_lh (
        .a_i(in_a[H-1:0]), .a_signed_i(1'b0),
        .b_i(in_b[W-1:H]), .b_signed_i(sign_in_s.b_signed), .p_o(pp_lh_s));
    kernel_nios2_mul_pp #(.H(H)) u_pp_hl (
        .a_i(in_a[W-1:H]), .a_signed_i(sign_in_s.a_signed),
        .b_i(in_b[H-1:0]), .b_signed_i(1'b0), .p_o(pp_hl_s));
    kernel_nios2_mul_pp #(.H(H)) u_pp_hh (
        .a_i(in_a[W-1:H]), .a_signed_i(sign_in_s.a_signed),
        .b_i(in_b[W-1:H]), .b_signed_i(sign_in_s.b_signed), .p_o(pp_hh_s));

    // Ready ripples back from the output; no skid buffer, so this is a pure chain.
    assign adv_b_s  = !vb_q || out_ready;
    assign adv_a_s  = !va_q || adv_b_s;
    assign in_ready = !flush && adv_a_s;
    assign accept_s = in_valid && in_ready;

    // Stage A next state: capture partial products on accept, hold when stalled.
    always_comb begin
        va_d    = va_q;
        op_a_d  = op_a_q;
        tag_a_d = tag_a_q;
        pp_ll_d = pp_ll_q;
        pp_lh_d = pp_lh_q;
        pp_hl_d = pp_hl_q;
        pp_hh_d = pp_hh_q;
        if (flush) begin
            va_d = 1'b0;
        end else if (adv_a_s) begin
            va_d = accept_s;
            if (accept_s) begin
                op_a_d  = op_in_s;
                tag_a_d = in_tag;
                pp_ll_d = pp_ll_s;
                pp_lh_d = pp_lh_s;
                pp_hl_d = pp_hl_s;
                pp_hh_d = pp_hh_s;
            end else begin
                op_a_d = op_a_q;
            end
        end else begin
            va_d = va_q;
        end
    end

    // Partial products are signed W+2 bits; sign-extend to the 2W-bit sum width.
    assign ll_ext_s = {{(2*W-PW){pp_ll_q[PW-1]}}, pp_ll_q};
    assign lh_ext_s = {{(2*W-PW){pp_lh_q[PW-1]}}, pp_lh_q};
    assign hl_ext_s = {{(2*W-PW){pp_hl_q[PW-1]}}, pp_hl_q};
    assign hh_ext_s = {{(2*W-PW){pp_hh_q[PW-1]}}, pp_hh_q};
    assign sum_s    = ll_ext_s + ((lh_ext_s + hl_ext_s) << H) + (hh_ext_s << W);

    // Result word select by op.
    always_comb begin
        case (op_a_q)
            OP_MUL:  res_sel_s = sum_s[W-1:0];
            default: res_sel_s = sum_s[2*W-1:W];
        endcase
    end

    // Stage B next state: take stage A's result when the output slot frees up.
    always_comb begin
        vb_d    = vb_q;
        res_d   = res_q;
        tag_b_d = tag_b_q;
        if (flush) begin
            vb_d = 1'b0;
        end else if (adv_b_s) begin
            vb_d = va_q;
            if (va_q) begin
                res_d   = res_sel_s;
                tag_b_d = tag_a_q;
            end else begin
                res_d = res_q;
            end
        end else begin
            vb_d = vb_q;
        end
    end

    // Pipeline registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            va_q    <= 1'b0;
            op_a_q  <= OP_MUL;
            tag_a_q <= {TAG_W{1'b0}};
            pp_ll_q <= {PW{1'b0}};
            pp_lh_q <= {PW{1'b0}};
            pp_hl_q <= {PW{1'b0}};
            pp_hh_q <= {PW{1'b0}};
            vb_q    <= 1'b0;
            res_q   <= {W{1'b0}};
            tag_b_q <= {TAG_W{1'b0}};
        end else begin
            va_q    <= va_d;
            op_a_q  <= op_a_d;
            tag_a_q <= tag_a_d;
            pp_ll_q <= pp_ll_d;
            pp_lh_q <= pp_lh_d;
            pp_hl_q <= pp_hl_d;
            pp_hh_q <= pp_hh_d;
            vb_q    <= vb_d;
            res_q   <= res_d;
            tag_b_q <= tag_b_d;
        end
    end

    assign out_valid  = vb_q;
    assign out_result = res_q;
    assign out_tag    = tag_b_q;

endmodule

// File: tb/tb_kernel_nios2_mul_unit.sv
// Scoreboard bench for kernel_nios2_mul_unit at W=32: expected words are queued
// on acceptance and popped when a result is consumed.
module tb_kernel_nios2_mul_unit;

    localparam int W     = 32;
    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [1:0]       in_op;
    logic [W-1:0]     in_a, in_b, out_result;
    logic [TAG_W-1:0] in_tag, out_tag;

    typedef struct {
        logic [W-1:0]     res;
        logic [TAG_W-1:0] tag;
        int               acc;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    kernel_nios2_mul_unit #(.W(W), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // 64-bit reference: multiply the extended operands, keep 64 bits, pick a word.
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, b);
        logic [63:0] ax, bx, p;
        ax = (op == 2'd1 || op == 2'd2) ? {{32{a[31]}}, a} : {32'd0, a};
        bx = (op == 2'd1) ? {{32{b[31]}}, b} : {32'd0, b};
        p  = ax * bx;
        case (op)
            2'd0:    return p[31:0];
            default: return p[63:32];
        endcase
    endfunction

    // Drive one cycle of inputs at the falling edge; queue the expectation if accepted.
    task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a, b,
                         input logic [4:0] tag, input logic ordy, input logic fl,
                         input logic [31:0] expv, output logic acc);
        exp_t e;
        in_valid  = v;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        in_tag    = tag;
        out_ready = ordy;
        flush     = fl;
        #1;
        acc = v && in_ready;
        if (acc) begin
            e.res = expv;
            e.tag = tag;
            e.acc = cyc;
            sbq.push_back(e);
        end
    endtask

    task automatic test_reset();
        n_cmp++;
        if (out_valid !== 1'b0 || out_result !== 32'd0 || out_tag !== 5'd0) begin
            n_bad++;
            $display("FAIL reset_outputs got valid=%b result=%h tag=%h want 0/0/0",
                     out_valid, out_result, out_tag);
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_corner_ops(input string name, input logic [31:0] a, b,
                                   input logic [31:0] e_mul, e_ss, e_su, e_uu);
        logic [31:0] ev [4];
        logic        acc;
        exp_t        e;
        ev[0] = e_mul; ev[1] = e_ss; ev[2] = e_su; ev[3] = e_uu;
        for (int i = 0; i < 8; i++) begin
            if (i < 4) drive(1'b1, 2'(i), a, b, 5'(i), 1'b1, 1'b0, ev[i], acc);
            else       drive(1'b0, 2'd0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0, 32'd0, acc);
            if (i < 4) begin
                n_cmp++;
                if (acc !== 1'b1) begin
                    n_bad++;
                    $display("FAIL %s_accept op=%0d got in_ready=%b want 1", name, i, in_ready);
                end
            end
            if (out_valid) begin
                n_cmp++;
                if (sbq.size() == 0) begin
                    n_bad++;
                    $display("FAIL %s_phantom got result %h want no output", name, out_result);
                end else begin
                    e = sbq.pop_front();
                    if (out_result !== e.res || out_tag !== e.tag || cyc - e.acc != 2) begin
                        n_bad++;
                        $display("FAIL %s_result got %h tag %0d lat %0d want %h tag %0d lat 2",
                                 name, out_result, out_tag, cyc - e.acc, e.res, e.tag);
                    end
                end
            end
            @(negedge clk);
        end
        n_cmp++;
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL %s_drain got %0d outstanding want 0", name, sbq.size());
            sbq.delete();
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  op;
        logic [31:0] a, b;
        logic        acc;
        exp_t        e;
        int          pops = 0;
        for (int i = 0; i < 104; i++) begin
            if (i < 100) begin
                op = 2'($urandom_range(0, 3));
                a  = $urandom;
                b  = $urandom;
                if (i % 10 == 3) a = 32'h8000_0000;
                if (i % 10 == 7) b = 32'hFFFF_FFFF;
                drive(1'b1, op, a, b, 5'(i % 32), 1'b1, 1'b0, model(op, a, b), acc);
                n_cmp++;
                if (acc !== 1'b1) begin
                    n_bad++;
                    $display("FAIL b2b_accept i=%0d got in_ready=%b want 1", i, in_ready);
                end
            end else begin
                drive(1'b0, 2'd0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0, 32'd0, acc);
            end
            if (i >= 2 && i < 102) begin
                n_cmp++;
                if (out_valid !== 1'b1) begin
                    n_bad++;
                    $display("FAIL b2b_rate cycle=%0d got out_valid=%b want 1", i, out_valid);
                end
            end
            if (out_valid) begin
                n_cmp++;
                pops++;
                if (sbq.size() == 0) begin
                    n_bad++;
                    $display("FAIL b2b_phantom got result %h want no output", out_result);
                end else begin
                    e = sbq.pop_front();
                    if (out_result !== e.res || out_tag !== e.tag || cyc - e.acc != 2) begin
                        n_bad++;
                        $display("FAIL b2b_result got %h tag %0d lat %0d want %h tag %0d lat 2",
                                 out_result, out_tag, cyc - e.acc, e.res, e.tag);
                    end
                end
            end
            @(negedge clk);
        end
        n_cmp++;
        if (pops != 100 || sbq.size() != 0) begin
            n_bad++;
            $display("FAIL b2b_count got %0d results want 100", pops);
            sbq.delete();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] a, b, held_r;
        logic [4:0]  held_t;
        logic        acc, have;
        exp_t        e;
        int          n_acc = 0;
        int          pops  = 0;
        have = 1'b0;
        held_r = 32'd0;
        held_t = 5'd0;
        for (int i = 0; i < 10; i++) begin
            a = $urandom;
            b = $urandom;
            drive(1'b1, 2'(i % 4), a, b, 5'(16 + i), 1'b0, 1'b0, model(2'(i % 4), a, b), acc);
            if (acc) n_acc++;
            if (i >= 2) begin
                n_cmp++;
                if (in_ready !== 1'b0) begin
                    n_bad++;
                    $display("FAIL bp_in_ready cycle=%0d got %b want 0", i, in_ready);
                end
            end
            if (out_valid) begin
                if (!have) begin
                    held_r = out_result;
                    held_t = out_tag;
                    have   = 1'b1;
                end else begin
                    n_cmp++;
                    if (out_result !== held_r || out_tag !== held_t) begin
                        n_bad++;
                        $display("FAIL bp_stable got %h tag %0d want %h tag %0d",
                                 out_result, out_tag, held_r, held_t);
                    end
                end
            end
            @(negedge clk);
        end
        n_cmp++;
        if (n_acc != 2) begin
            n_bad++;
            $display("FAIL bp_accepted got %0d want 2", n_acc);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 2'd0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0, 32'd0, acc);
            if (i == 0) begin
                n_cmp++;
                if (in_ready !== 1'b1) begin
                    n_bad++;
                    $display("FAIL bp_release_ready got %b want 1", in_ready);
                end
            end
            if (out_valid) begin
                n_cmp++;
                pops++;
                if (sbq.size() == 0) begin
                    n_bad++;
                    $display("FAIL bp_phantom got result %h want no output", out_result);
                end else begin
                    e = sbq.pop_front();
                    if (out_result !== e.res || out_tag !== e.tag) begin
                        n_bad++;
                        $display("FAIL bp_drain got %h tag %0d want %h tag %0d",
                                 out_result, out_tag, e.res, e.tag);
                    end
                end
            end
            @(negedge clk);
        end
        n_cmp++;
        if (pops != 2 || sbq.size() != 0) begin
            n_bad++;
            $display("FAIL bp_drain_count got %0d want 2", pops);
            sbq.delete();
        end
    endtask

    task automatic test_flush();
        logic [31:0] a, b;
        logic        acc;
        exp_t        e;
        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            b = $urandom;
            if (i == 0 || i == 1 || i == 3) begin
                drive(1'b1, 2'(i), a, b, 5'(8 + i), 1'b1, 1'b0, model(2'(i), a, b), acc);
                n_cmp++;
                if (acc !== 1'b1) begin
                    n_bad++;
                    $display("FAIL flush_accept cycle=%0d got in_ready=%b want 1", i, in_ready);
                end
            end else if (i == 2) begin
                drive(1'b1, 2'd3, a, b, 5'd31, 1'b1, 1'b1, model(2'd3, a, b), acc);
                n_cmp++;
                if (acc !== 1'b0) begin
                    n_bad++;
                    $display("FAIL flush_reject got in_ready=%b want 0", in_ready);
                end
            end else begin
                drive(1'b0, 2'd0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0, 32'd0, acc);
            end
            if (i == 3 || i == 4) begin
                n_cmp++;
                if (out_valid !== 1'b0) begin
                    n_bad++;
                    $display("FAIL flush_stale cycle=%0d got out_valid=%b tag %0d want 0",
                             i, out_valid, out_tag);
                end
            end
            if (out_valid) begin
                n_cmp++;
                if (sbq.size() == 0) begin
                    n_bad++;
                    $display("FAIL flush_phantom got result %h want no output", out_result);
                end else begin
                    e = sbq.pop_front();
                    if (out_result !== e.res || out_tag !== e.tag || cyc - e.acc != 2) begin
                        n_bad++;
                        $display("FAIL flush_result got %h tag %0d lat %0d want %h tag %0d lat 2",
                                 out_result, out_tag, cyc - e.acc, e.res, e.tag);
                    end
                end
            end
            if (i == 2) sbq.delete();
            @(negedge clk);
        end
        n_cmp++;
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL flush_drain got %0d outstanding want 0", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] a, b;
        logic        acc;
        exp_t        e;
        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            b = $urandom;
            reset = (i == 2);
            if (i < 2 || i == 4) begin
                drive(1'b1, 2'(i), a, b, 5'(20 + i), (i == 4), 1'b0, model(2'(i), a, b), acc);
            end else begin
                drive(1'b0, 2'd0, 32'd0, 32'd0, 5'd0, (i != 2), 1'b0, 32'd0, acc);
            end
            if (i == 3) begin
                n_cmp++;
                if (out_valid !== 1'b0 || out_result !== 32'd0 || out_tag !== 5'd0 ||
                    in_ready !== 1'b1) begin
                    n_bad++;
                    $display("FAIL rstmid_clear got valid=%b result=%h tag=%0d ready=%b want 0/0/0/1",
                             out_valid, out_result, out_tag, in_ready);
                end
            end
            if (i == 4 || i == 5) begin
                n_cmp++;
                if (out_valid !== 1'b0) begin
                    n_bad++;
                    $display("FAIL rstmid_phantom cycle=%0d got out_valid=%b want 0", i, out_valid);
                end
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (sbq.size() == 0) begin
                    n_bad++;
                    $display("FAIL rstmid_extra got result %h want no output", out_result);
                end else begin
                    e = sbq.pop_front();
                    if (out_result !== e.res || out_tag !== e.tag || cyc - e.acc != 2) begin
                        n_bad++;
                        $display("FAIL rstmid_result got %h tag %0d lat %0d want %h tag %0d lat 2",
                                 out_result, out_tag, cyc - e.acc, e.res, e.tag);
                    end
                end
            end
            if (i == 2) sbq.delete();
            @(negedge clk);
        end
        n_cmp++;
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL rstmid_drain got %0d outstanding want 0", sbq.size());
            sbq.delete();
        end
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 2'd0;
        in_a      = 32'd0;
        in_b      = 32'd0;
        in_tag    = 5'd0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        test_corner_ops("ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                        32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        test_corner_ops("minint", 32'h8000_0000, 32'h8000_0000,
                        32'h0000_0000, 32'h4000_0000, 32'hC000_0000, 32'h4000_0000);
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/kernel_nios2_mul_unit.md
# kernel_nios2_mul_unit

Parametrised, pipelined integer multiplier for the Nios II kernel datapath. It supports four multiply modes (low word, and signed/mixed/unsigned high word), configurable operand width, a valid/ready handshake with backpressure, and a flush. It replaces the fixed 16×16 three-partial-product cell, producing the final selected result word itself instead of leaving partial-product summation to the ALU.

## Interface
- W, 32: operand and result width; even, 8..64.
- TAG_W, 5: width of the opaque tag (destination register index) carried alongside each operation.
- clk  in  1  clock; all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  discard all in-flight operations this cycle.
- in_valid  in  1  operation offered.
- in_ready  out  1  operation accepted when in_valid && in_ready.
- in_op  in  2  0 MUL, 1 MULXSS, 2 MULXSU, 3 MULXUU.
- in_a  in  W  operand A.
- in_b  in  W  operand B.
- in_tag  in  TAG_W  returned unchanged with the result.
- out_valid  out  1  result presented.
- out_ready  in  1  result consumed when out_valid && out_ready.
- out_result  out  W  selected result word.
- out_tag  out  TAG_W  tag of the presented result.

## Operation
- Arithmetic is defined on 2W-bit products:
  - MUL: low W bits of a*b. Signedness is irrelevant.
  - MULXSS: bits [2W-1:W] of signed(a)*signed(b).
  - MULXSU: bits [2W-1:W] of signed(a)*unsigned(b).
  - MULXUU: bits [2W-1:W] of unsigned(a)*unsigned(b).
- Operand split with H=W/2:
  - a_lo = a[H-1:0] and b_lo = b[H-1:0], always zero-extended.
  - a_hi and b_hi are the upper H bits extended to H+1 bits: sign-extended if that operand is signed in the op, else zero-extended.
- Stage A registers four partial products: lo·lo (2H bits unsigned), lo·hi, hi·lo, hi·hi (signed 2H+2 bits). It also registers op and tag.
- Stage B:
  - sum = pp_ll + (pp_lh + pp_hl)<<H + pp_hh<<W, computed modulo 2^(2W).
  - Selects the low or high word per op.
  - Registers result and tag.
- Each stage has a valid bit. There are no other state machines.
- Stage B loads when advB = !vB || out_ready.
- Stage A loads when advA = !vA || advB.
- in_ready = !flush && advA. This is a combinational chain, with no skid buffer.
- A stalled stage holds its data and valid unchanged.
- Flush clears vA and vB at the clock edge. An input offered in a flush cycle is not accepted (in_ready=0). out_valid drops the cycle after flush.
- Flush and out_ready in the same cycle: the presented result counts as consumed, and the entry is cleared either way.
- Reset clears vA, vB, out_result, out_tag and all stage data registers to 0. in_ready is 1 from the first cycle after reset deasserts.
- Reset mid-operation discards all in-flight operations. No output appears for them.

## Timing
- Latency: accepted at edge N, out_valid=1 in the cycle following edge N+2. That is 2 cycles of registers, with no combinational path from in_* to out_result.
- Throughput: 1 op/cycle while out_ready=1.
- With out_ready=0 held, at most 2 ops are accepted. in_ready then falls, and out_result/out_tag stay stable until the handshake.
- out_result, out_tag and out_valid are registered outputs. in_ready depends combinationally on out_ready and flush only.
- Ordering is strictly FIFO. Tags return in acceptance order.

## Structure
- Package kernel_nios2_mul_pkg holds:
  - the op enum (MUL, MULXSS, MULXSU, MULXUU);
  - localparam MUL_LATENCY=2;
  - a function giving the signedness of A and B per op.
- Sub-module kernel_nios2_mul_pp: a single (H+1)×(H+1) signed multiplier with per-operand extension control. It is instantiated four times in stage A and maps onto a DSP block.
- The top level holds the stage registers, the handshake, the adder tree and the result select.

## Test plan
- All tests use W=32.
- a=b=0xFFFFFFFF, each op in turn, out_ready=1 → MUL 0x00000001, MULXSS 0x00000000, MULXSU 0xFFFFFFFF, MULXUU 0xFFFFFFFE; each appears exactly 2 cycles after acceptance.
- Back-to-back stream of 100 random ops with tags 0..31 cycling and out_ready=1 → one result per cycle; tags in order; every result matches a 64-bit reference model.
- out_ready=0 for 10 cycles with in_valid=1 → exactly 2 accepted, in_ready=0 afterwards, and out_result stable. Releasing out_ready drains both in order; in_ready reasserts in the same cycle.
- a=0x80000000, b=0x80000000 → MULXSS 0x40000000, MULXSU 0xC0000000, MULXUU 0x40000000, MUL 0x00000000.
- Two ops in flight, then flush with in_valid=1 → that input is not accepted, no stale result appears, and a new op issued the next cycle returns normally 2 cycles later.
- Reset asserted with 2 ops in flight → out_valid=0 and out_result=0 the cycle after, in_ready=1 once reset is released, and no phantom outputs.
